// File: rtl/fpalu_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpalu_addsub_pipe
// Brief    : 3-stage pipelined floating-point adder/subtractor, RNE, FTZ.
// Revision : 1.0 - initial release
// ============================================================================
module fpalu_addsub_pipe #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int DENORM_FTZ = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a_input,
    input  logic [EXP_W+MAN_W:0] b_input,
    input  logic                 op_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] sum,
    output logic [3:0]           flags
);
    localparam int c_W     = 1 + EXP_W + MAN_W;
    localparam int c_N     = MAN_W + 1;      // significand incl. hidden bit
    localparam int c_AW    = MAN_W + 4;      // significand + guard/round/sticky
    localparam int c_SW    = MAN_W + 5;      // aligned sum incl. carry bit
    localparam int c_WIDE  = 2 * MAN_W + 4;
    localparam int c_SHMAX = MAN_W + 3;
    localparam int c_SHW   = $clog2(MAN_W + 4);
    localparam int c_LZW   = $clog2(MAN_W + 6);
    localparam int c_EW    = EXP_W + c_LZW + 2;

    // ---------------- pipeline control ----------------
    logic r_v1, r_v2, r_v3;
    logic w_adv;
    assign w_adv     = out_ready | ~r_v3;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;

    // ---------------- stage 1: unpack, swap, align ----------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb, w_e_big, w_e_sml, w_diff;
    logic [MAN_W-1:0] w_fa, w_fb, w_f_big, w_f_sml;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic             w_swap, w_s_big;
    logic [c_N-1:0]   w_sig_sml;
    logic [c_SHW-1:0] w_sh;
    logic [c_WIDE-1:0] w_wide;
    logic [c_AW-1:0]  w_big_al, w_sml_al;
    logic             w_nan, w_inf, w_isign;

    assign w_sa = a_input[c_W-1];
    assign w_sb = b_input[c_W-1] ^ op_sub;
    assign w_ea = a_input[MAN_W +: EXP_W];
    assign w_eb = b_input[MAN_W +: EXP_W];
    // Subnormal operands are treated as signed zero: drop their fraction.
    assign w_fa = (w_ea == '0 && DENORM_FTZ != 0) ? '0 : a_input[MAN_W-1:0];
    assign w_fb = (w_eb == '0 && DENORM_FTZ != 0) ? '0 : b_input[MAN_W-1:0];

    assign w_a_nan = (&w_ea) & (|w_fa);
    assign w_b_nan = (&w_eb) & (|w_fb);
    assign w_a_inf = (&w_ea) & ~(|w_fa);
    assign w_b_inf = (&w_eb) & ~(|w_fb);
    assign w_nan   = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa ^ w_sb));
    assign w_inf   = w_a_inf | w_b_inf;
    assign w_isign = w_a_inf ? w_sa : w_sb;

    assign w_swap    = {w_eb, w_fb} > {w_ea, w_fa};
    assign w_e_big   = w_swap ? w_eb : w_ea;
    assign w_e_sml   = w_swap ? w_ea : w_eb;
    assign w_f_big   = w_swap ? w_fb : w_fa;
    assign w_f_sml   = w_swap ? w_fa : w_fb;
    assign w_s_big   = w_swap ? w_sb : w_sa;
    assign w_diff    = w_e_big - w_e_sml;
    assign w_sig_sml = {(|w_e_sml), w_f_sml};

    // Beyond MAN_W+3 places the smaller operand only ever reaches sticky.
    assign w_sh     = (32'(w_diff) >= 32'(c_SHMAX)) ? c_SHW'(c_SHMAX) : c_SHW'(w_diff);
    assign w_wide   = {w_sig_sml, {c_SHMAX{1'b0}}} >> w_sh;
    assign w_sml_al = {w_wide[c_WIDE-1 -: c_N+2], |w_wide[c_N-1:0]};
    assign w_big_al = {(|w_e_big), w_f_big, 3'b000};

    logic             r_s1_sign, r_s1_sub, r_s1_nan, r_s1_inf, r_s1_isign;
    logic [EXP_W-1:0] r_s1_exp;
    logic [c_AW-1:0]  r_s1_big, r_s1_sml;

    // ---------------- stage 2: magnitude add/subtract ----------------
    logic [c_SW-1:0]  w_mag;
    assign w_mag = r_s1_sub ? ({1'b0, r_s1_big} - {1'b0, r_s1_sml})
                            : ({1'b0, r_s1_big} + {1'b0, r_s1_sml});

    logic             r_s2_sign, r_s2_sub, r_s2_nan, r_s2_inf, r_s2_isign;
    logic [EXP_W-1:0] r_s2_exp;
    logic [c_SW-1:0]  r_s2_mag;

    // ---------------- stage 3: normalise, round, pack ----------------
    logic [c_LZW-1:0] w_lz;
    logic [c_SW-1:0]  w_norm;
    logic             w_g, w_rs, w_up, w_rcarry, w_mzero, w_ovf, w_unf;
    logic [MAN_W-1:0] w_frac;
    logic [c_EW-1:0]  w_e;
    logic [c_W-1:0]   w_res;
    logic [3:0]       w_flg;

    always_comb begin
        w_lz = c_LZW'(c_SW);
        for (int i = 0; i < c_SW; i++) begin
            if (r_s2_mag[i]) w_lz = c_LZW'(c_SW - 1 - i);
        end
    end

    assign w_norm   = r_s2_mag << w_lz;
    assign w_mzero  = ~w_norm[c_SW-1];
    assign w_g      = w_norm[3];
    assign w_rs     = |w_norm[2:0];
    assign w_up     = w_g & (w_rs | w_norm[4]);
    assign w_rcarry = (&w_norm[c_SW-2:4]) & w_up;
    assign w_frac   = w_norm[c_SW-2:4] + MAN_W'(w_up);
    // Hidden bit sits one place above its stage-2 home, hence the +1.
    assign w_e      = c_EW'(r_s2_exp) + c_EW'(w_rcarry) + c_EW'(1) - c_EW'(w_lz);
    assign w_ovf    = ~w_e[c_EW-1] &&
                      (w_e[c_EW-2:0] >= {{(c_EW-1-EXP_W){1'b0}}, {EXP_W{1'b1}}});
    assign w_unf    = w_e[c_EW-1] || (w_e == '0);

    always_comb begin
        w_res = '0;
        w_flg = 4'b0000;
        if (r_s2_nan) begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_flg = 4'b1000;
        end else if (r_s2_inf) begin
            w_res = {r_s2_isign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_mzero) begin
            w_res = {r_s2_sub ? 1'b0 : r_s2_sign, {(c_W-1){1'b0}}};
        end else if (w_ovf) begin
            w_res = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flg = 4'b0101;
        end else if (w_unf) begin
            w_res = {r_s2_sign, {(c_W-1){1'b0}}};
            w_flg = 4'b0011;
        end else begin
            w_res = {r_s2_sign, w_e[EXP_W-1:0], w_frac};
            w_flg = {3'b000, w_g | w_rs};
        end
    end

    logic [c_W-1:0] r_sum;
    logic [3:0]     r_flags;
    assign sum   = r_sum;
    assign flags = r_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_sub   <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_isign <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_big   <= '0;
            r_s1_sml   <= '0;
            r_s2_sign  <= 1'b0;
            r_s2_sub   <= 1'b0;
            r_s2_nan   <= 1'b0;
            r_s2_inf   <= 1'b0;
            r_s2_isign <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_mag   <= '0;
            r_sum      <= '0;
            r_flags    <= 4'b0000;
        end else if (w_adv) begin
            r_v1       <= in_valid;
            r_s1_sign  <= w_s_big;
            r_s1_sub   <= w_sa ^ w_sb;
            r_s1_nan   <= w_nan;
            r_s1_inf   <= w_inf;
            r_s1_isign <= w_isign;
            r_s1_exp   <= w_e_big;
            r_s1_big   <= w_big_al;
            r_s1_sml   <= w_sml_al;

            r_v2       <= r_v1;
            r_s2_sign  <= r_s1_sign;
            r_s2_sub   <= r_s1_sub;
            r_s2_nan   <= r_s1_nan;
            r_s2_inf   <= r_s1_inf;
            r_s2_isign <= r_s1_isign;
            r_s2_exp   <= r_s1_exp;
            r_s2_mag   <= w_mag;

            r_v3       <= r_v2;
            if (r_v2) begin
                r_sum   <= w_res;
                r_flags <= w_flg;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fpalu_addsub_pipe.md
FPALU_ADDSUB_PIPE -- requirements
Module: fpalu_addsub_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8: exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23: stored fraction width, with total word width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have parameter DENORM_FTZ, default 1: flush subnormal inputs and outputs to signed zero (only value 1 required).
REQ-004 The block SHALL have port clk, input, 1: the single clock, with all state rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1: operand pair valid.
REQ-007 The block SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-008 The block SHALL have port a_input, input, W: operand A, IEEE-754-style layout {sign, exp, frac}.
REQ-009 The block SHALL have port b_input, input, W: operand B.
REQ-010 The block SHALL have port op_sub, input, 1: 0 computes A+B, 1 computes A-B (B sign inverted).
REQ-011 The block SHALL have port out_valid, output, 1: result valid.
REQ-012 The block SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 The block SHALL have port sum, output, W: result.
REQ-014 The block SHALL have port flags, output, 4: {invalid, overflow, underflow, inexact} for the result on sum.

Function
REQ-015 The block SHALL be a 3-stage pipeline:
- S1: unpack, swap by magnitude ({exp,frac} compare, not exponent only), align the smaller significand with guard/round/sticky.
- S2: signed-magnitude add/subtract with 1 overflow bit.
- S3: leading-zero normalise, round, pack, set flags.
REQ-016 Latency SHALL be exactly 3 clk cycles from an accepted input (in_valid && in_ready) to out_valid when out_ready is held high.
REQ-017 With out_ready high, the block SHALL accept one operation per cycle.
REQ-018 Stall rule:
- advance = out_ready || !out_valid.
- in_ready = advance.
- When advance=0, all stages SHALL hold.
- sum and flags SHALL remain stable while out_valid && !out_ready.
REQ-019 Empty slots SHALL propagate as bubbles with valid=0; bubbles SHALL NOT be squeezed out while stalled.
REQ-020 The alignment shift SHALL saturate: an exponent difference of at least MAN_W+3 SHALL leave the smaller operand contributing to sticky only.
REQ-021 Rounding SHALL be round-to-nearest, ties-to-even, using guard/round/sticky bits.
REQ-022 A carry out of rounding SHALL renormalise and increment the exponent.
REQ-023 Exact cancellation SHALL produce +0.
REQ-024 (-0)+(-0) SHALL produce -0.
REQ-025 A rounded exponent of at least all-ones SHALL produce signed infinity, with overflow=1 and inexact=1.
REQ-026 A result below the minimum normal SHALL produce signed zero, with underflow=1, and inexact=1 if the result is nonzero.
REQ-027 Special operands:
- Any NaN operand, or inf-inf of opposite effective sign, SHALL produce canonical quiet NaN {0, all-ones, 1 followed by zeros} with invalid=1.
- inf plus a finite value SHALL produce that inf, with flags 0.
REQ-028 inexact SHALL be 1 whenever any discarded bit is nonzero.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously clear all stage valid bits to 0, giving out_valid=0, sum=0 and flags=0.
REQ-030 While rst_n=0, in_ready SHALL be 1, since the pipeline is empty.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations with no partial output.
REQ-032 After rst_n deasserts, the first accepted operation SHALL emerge exactly 3 cycles later.

Verification
REQ-033 Scenario, add: a=0x3F800000, b=0x3F800000, op_sub=0, out_ready=1 -> sum=0x40000000 with flags=0, exactly 3 cycles after acceptance.
REQ-034 Scenario, cancellation: a=0x3FC00000, b=0x3FC00000, op_sub=1 -> sum=0x00000000, flags=0.
REQ-035 Scenario, rounding tie: a=0x3F800000 (1.0), b=0x33800000 (2^-24) -> sum=0x3F800000 (ties-to-even), flags=0001.
REQ-036 Scenario, overflow: a=0x7F7FFFFF, b=0x7F7FFFFF -> sum=0x7F800000, flags=0101.
REQ-037 Scenario, invalid: a=0x7F800000, b=0xFF800000 -> sum=0x7FC00000, flags=1000.
REQ-038 Scenario, backpressure: stream 5 ops back-to-back, drop out_ready for 4 cycles mid-stream -> in_ready falls in the same cycle, the held sum is unchanged, all 5 results arrive in order with none lost or duplicated, and reset asserted mid-stream yields out_valid=0 immediately.
